// File: rtl/dffnre_wr_arbiter_pkg.sv
// Shared types and sizing helpers for the DFFNRE bank write arbiter.
package dffnre_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    COOL  = 2'd2
  } arb_state_e;

  localparam int unsigned CNT_W       = 4;
  localparam int unsigned NUM_REQ_DEF = 4;
  localparam int unsigned IDX_W       = $clog2(NUM_REQ_DEF);

  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dffnre_wr_arbiter_if.sv
// Requester/bank-side bus of the write arbiter; slave = arbiter, master = requester logic.
interface dffnre_wr_arbiter_if
  import dffnre_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8
);
  localparam int unsigned GID_W = idx_width(NUM_REQ);

  logic [NUM_REQ-1:0]            REQ;
  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA;
  logic [NUM_REQ-1:0]            GNT;
  logic [NUM_REQ-1:0]            ACK;
  logic                          E;
  logic [DATA_WIDTH-1:0]         D;
  logic [GID_W-1:0]              GNT_ID;
  logic                          BUSY;

  modport master (
    output REQ, REQ_DATA,
    input  GNT, ACK, E, D, GNT_ID, BUSY
  );

  modport slave (
    input  REQ, REQ_DATA,
    output GNT, ACK, E, D, GNT_ID, BUSY
  );

endinterface

// File: rtl/dffnre_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after i_ptr, wrapping.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [IDX_W-1:0]   o_sel,
  output logic               o_valid
);

  logic [IDX_W:0] w_pos;

  always_comb begin
    o_sel   = '0;
    o_valid = 1'b0;
    w_pos   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_pos = {1'b0, i_ptr} + (IDX_W+1)'(i);
      if (w_pos >= (IDX_W+1)'(NUM_REQ)) begin
        w_pos = w_pos - (IDX_W+1)'(NUM_REQ);
      end
      if (!o_valid && i_req[w_pos[IDX_W-1:0]]) begin
        o_valid = 1'b1;
        o_sel   = w_pos[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/dffnre_wr_arbiter.sv
// Round-robin, burst-limited write arbiter driving E/D of a negedge-capture DFFNRE bank.
module dffnre_wr_arbiter
  import dffnre_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                C,
  input  logic                R,
  dffnre_wr_arbiter_if.slave  bus
);

  localparam int unsigned IW = idx_width(NUM_REQ);

  arb_state_e            r_state;
  logic [NUM_REQ-1:0]    r_gnt;
  logic [NUM_REQ-1:0]    r_ack;
  logic                  r_e;
  logic [DATA_WIDTH-1:0] r_d;
  logic [IW-1:0]         r_gnt_id;
  logic [IW-1:0]         r_ptr;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_busy;

  logic [IW-1:0]         w_sel;
  logic                  w_sel_vld;
  logic [NUM_REQ-1:0]    w_sel_oh;
  logic [NUM_REQ-1:0]    w_owner_oh;
  logic                  w_cont;
  logic [IW-1:0]         w_next_ptr;
  logic [DATA_WIDTH-1:0] w_slot [NUM_REQ];

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IW)
  ) u_pick (
    .i_req   (bus.REQ),
    .i_ptr   (r_ptr),
    .o_sel   (w_sel),
    .o_valid (w_sel_vld)
  );

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_slot[i] = bus.REQ_DATA[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign w_sel_oh   = NUM_REQ'(1) << w_sel;
  assign w_owner_oh = NUM_REQ'(1) << r_gnt_id;
  assign w_cont     = (r_state == GRANT) && bus.REQ[r_gnt_id] &&
                      (r_cnt < CNT_W'(MAX_BURST));
  assign w_next_ptr = (r_gnt_id == IW'(NUM_REQ-1)) ? '0 : r_gnt_id + IW'(1);

  // IDLE and COOL arbitrate identically; COOL only exists to force one E=0 negedge.
  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      r_state  <= IDLE;
      r_gnt    <= '0;
      r_ack    <= '0;
      r_e      <= 1'b0;
      r_d      <= '0;
      r_gnt_id <= '0;
      r_ptr    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        IDLE, COOL: begin
          if (w_sel_vld) begin
            r_state  <= GRANT;
            r_gnt    <= w_sel_oh;
            r_ack    <= w_sel_oh;
            r_e      <= 1'b1;
            r_d      <= w_slot[w_sel];
            r_gnt_id <= w_sel;
            r_busy   <= 1'b1;
            r_cnt    <= CNT_W'(1);
          end else begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_ack   <= '0;
            r_e     <= 1'b0;
            r_busy  <= 1'b0;
          end
        end
        GRANT: begin
          if (w_cont) begin
            r_ack <= w_owner_oh;
            r_e   <= 1'b1;
            r_d   <= w_slot[r_gnt_id];
            r_cnt <= r_cnt + CNT_W'(1);
          end else begin
            r_state <= COOL;
            r_gnt   <= '0;
            r_ack   <= '0;
            r_e     <= 1'b0;
            r_busy  <= 1'b0;
            r_ptr   <= w_next_ptr;
          end
        end
        default: begin
          r_state <= IDLE;
          r_gnt   <= '0;
          r_ack   <= '0;
          r_e     <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.GNT    = r_gnt;
  assign bus.ACK    = r_ack;
  assign bus.E      = r_e;
  assign bus.D      = r_d;
  assign bus.GNT_ID = r_gnt_id;
  assign bus.BUSY   = r_busy;

endmodule

// File: tb/tb_dffnre_wr_arbiter.sv
// Scoreboard bench: a behavioural arbiter model queues expected bank writes, a negedge monitor checks them.
module tb_dffnre_wr_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 4;

  logic C = 1'b0;
  logic R = 1'b0;

  dffnre_wr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(W)) bus ();

  dffnre_wr_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (W),
    .MAX_BURST  (MB)
  ) dut (
    .C   (C),
    .R   (R),
    .bus (bus.slave)
  );

  always #5 C = ~C;

  typedef struct {
    int          cyc;
    int          id;
    logic [W-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  compared   = 0;
  int  mismatched = 0;
  int  cyc        = 0;

  // Model: who owns the bank, how many writes so far, and where the next search starts.
  int m_owner = -1;
  int m_n     = 0;
  int m_start = 0;

  always @(posedge C) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endtask

  task automatic model_step(input logic [N-1:0] req, input logic [N*W-1:0] data);
    wr_t e;
    if (m_owner >= 0) begin
      if (req[m_owner] && m_n < MB) begin
        m_n++;
        e.cyc = cyc + 1; e.id = m_owner; e.data = data[m_owner*W +: W];
        exp_q.push_back(e);
      end else begin
        m_start = (m_owner + 1) % N;
        m_owner = -1;
      end
    end else if (req != 0) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_start + k) % N;
        if (req[c]) begin
          m_owner = c;
          m_n     = 1;
          e.cyc = cyc + 1; e.id = c; e.data = data[c*W +: W];
          exp_q.push_back(e);
          break;
        end
      end
    end
  endtask

  task automatic step(input logic [N-1:0] req, input logic [N*W-1:0] data);
    @(posedge C);
    #2;
    bus.REQ      = req;
    bus.REQ_DATA = data;
    model_step(req, data);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_E"},      32'(bus.E),      0);
    chk({tag, "_GNT"},    32'(bus.GNT),    0);
    chk({tag, "_ACK"},    32'(bus.ACK),    0);
    chk({tag, "_BUSY"},   32'(bus.BUSY),   0);
    chk({tag, "_GNT_ID"}, 32'(bus.GNT_ID), 0);
  endtask

  // Reset pulse between posedges; the model restarts from ptr=0 and sees the held REQ.
  task automatic async_reset_mid_burst();
    @(posedge C);
    #2;
    chk("rst_in_burst_BUSY", 32'(bus.BUSY), 1);
    R = 1'b0;
    #1;
    check_zero("rst_mid");
    exp_q.delete();
    m_owner = -1; m_n = 0; m_start = 0;
    #1;
    R = 1'b1;
    model_step(bus.REQ, bus.REQ_DATA);
  endtask

  always @(negedge C) begin
    if (R) begin
      chk("E_eq_orACK", 32'(bus.E), 32'(|bus.ACK));
      chk("BUSY_eq_E",  32'(bus.BUSY), 32'(bus.E));
      if (bus.E) begin
        logic [W-1:0] bank_q;
        bank_q = bus.D;
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_write @cyc %0d: got E=1 GNT_ID=%0d D=%0h, expected no write",
                   cyc, bus.GNT_ID, bus.D);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("write_cycle", 32'(cyc), 32'(e.cyc));
          chk("GNT_ID",      32'(bus.GNT_ID), 32'(e.id));
          chk("ACK_onehot",  32'(bus.ACK), 32'(1) << e.id);
          chk("GNT_onehot",  32'(bus.GNT), 32'(1) << e.id);
          chk("bank_Q",      32'(bank_q), 32'(e.data));
        end
      end else begin
        chk("GNT_when_E0", 32'(bus.GNT), 0);
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
          wr_t e;
          e = exp_q.pop_front();
          compared++;
          mismatched++;
          $display("FAIL missing_write @cyc %0d: got E=0, expected write id=%0d data=%0h",
                   cyc, e.id, e.data);
        end
      end
    end
  end

  initial begin
    logic [N-1:0] r;
    bus.REQ      = '0;
    bus.REQ_DATA = '0;
    #3;
    check_zero("reset");
    chk("reset_D", 32'(bus.D), 0);
    repeat (2) @(posedge C);
    #2;
    R = 1'b1;

    // Single requester, two writes
    step(4'b0001, 32'h0000_00A5);
    step(4'b0001, 32'h0000_003C);
    repeat (4) step(4'b0000, 32'h0);

    // Burst limit with a lone requester
    repeat (10) step(4'b0100, {$urandom});
    repeat (3) step(4'b0000, 32'h0);

    // Full round robin
    repeat (22) step(4'b1111, {$urandom});
    repeat (3) step(4'b0000, 32'h0);

    // Owner drops while another waits
    repeat (2) step(4'b1010, {$urandom});
    repeat (6) step(4'b1000, {$urandom});
    repeat (2) step(4'b0000, 32'h0);

    // Async reset in the middle of a burst
    repeat (3) step(4'b1111, {$urandom});
    async_reset_mid_burst();
    repeat (6) step(4'b1111, {$urandom});
    repeat (3) step(4'b0000, 32'h0);

    // Simultaneous pair
    repeat (12) step(4'b0110, {$urandom});
    repeat (3) step(4'b0000, 32'h0);

    // Random level requests
    r = '0;
    for (int t = 0; t < 400; t++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(3) == 0) r[b] = ~r[b];
      end
      step(r, {$urandom});
    end
    repeat (5) step(4'b0000, 32'h0);

    @(negedge C);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
